// File: rtl/jk_pkg.sv
// Shared mode encodings for the JK counter register.
package jk_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        JK         = 2'b00,
        LOAD       = 2'b01,
        COUNT_UP   = 2'b10,
        COUNT_DOWN = 2'b11
    } mode_e;

endpackage : jk_pkg

// File: rtl/jkff_cell.sv
// Single JK flip-flop bit with asynchronous active-low reset to RST_BIT.
module jkff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // JK rule: 00 hold, 01 clear, 10 set, 11 toggle
    always_comb begin
        q_d = q_q;
        unique case ({j, k})
            2'b00: q_d = q_q;
            2'b01: q_d = 1'b0;
            2'b10: q_d = 1'b1;
            2'b11: q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // State register, reset wins immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= RST_BIT;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule : jkff_cell

// File: rtl/jk_counter_reg.sv
// WIDTH-bit register built from JK cells: per-bit JK, parallel load,
// up/down counting, combinational terminal count and a registered wrap pulse.
module jk_counter_reg
    import jk_pkg::*;
#(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  j,
    input  logic [WIDTH-1:0]  k,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_bar,
    output logic              tc,
    output logic              wrap
);

    logic [WIDTH-1:0] q_int;
    logic [WIDTH-1:0] ones_below;   // bit i: all lower bits of q are 1
    logic [WIDTH-1:0] zeros_below;  // bit i: all lower bits of q are 0
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             wrap_q;
    logic             wrap_d;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    // One JK cell per bit plus the carry/borrow prefix that gates toggling
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign ones_below[i]  = 1'b1;
            assign zeros_below[i] = 1'b1;
        end else begin : g_upper
            assign ones_below[i]  = &q_int[i-1:0];
            assign zeros_below[i] = ~|q_int[i-1:0];
        end

        jkff_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .j   (cell_j[i]),
            .k   (cell_k[i]),
            .q   (q_int[i])
        );
    end

    // Per-bit J/K selection; en=0 drives J=K=0 so every cell holds
    always_comb begin
        cell_j = '0;
        cell_k = '0;
        if (en) begin
            unique case (mode_s)
                JK: begin
                    cell_j = j;
                    cell_k = k;
                end
                LOAD: begin
                    cell_j = d;
                    cell_k = ~d;
                end
                COUNT_UP: begin
                    cell_j = ones_below;
                    cell_k = ones_below;
                end
                COUNT_DOWN: begin
                    cell_j = zeros_below;
                    cell_k = zeros_below;
                end
                default: begin
                    cell_j = '0;
                    cell_k = '0;
                end
            endcase
        end
    end

    // Terminal count: the coming enabled edge rolls the counter over
    always_comb begin
        tc = 1'b0;
        if (en) begin
            if (mode_s == COUNT_UP   && (&q_int))  tc = 1'b1;
            if (mode_s == COUNT_DOWN && ~(|q_int)) tc = 1'b1;
        end
        wrap_d = tc;
    end

    // Wrap pulse is the terminal count delayed by one edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wrap_q <= 1'b0;
        else      wrap_q <= wrap_d;
    end

    assign q     = q_int;
    assign q_bar = ~q_int;
    assign wrap  = wrap_q;

endmodule : jk_counter_reg
